// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM data-path FIFOs.
// The defaults here match the SDRAM controller's word width and burst size.
package sdram_pkg;

    localparam int SDRAM_DATA_W    = 16;
    localparam int SDRAM_FIFO_ADDR = 10;
    localparam int SDRAM_BURST_LEN = 256;

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_RD   = 2'b01,
        FIFO_WR   = 2'b10,
        FIFO_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM, WIDTH x 2**ADDR, synchronous write and registered read.
// Array contents are not reset; only the read register clears on aclr.
module fifo_ram_sdp #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 10
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             wr_en,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ADDR-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [0:(2**ADDR)-1];
    logic [WIDTH-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port; a same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/sync_burst_fifo.sv
// Single-clock FIFO for the SDRAM data paths with level count, thresholds,
// burst-ready flag, flush, sticky error flags and optional show-ahead output.
module sync_burst_fifo
    import sdram_pkg::*;
#(
    parameter int WIDTH     = SDRAM_DATA_W,
    parameter int ADDR      = SDRAM_FIFO_ADDR,
    parameter int BURST_LEN = SDRAM_BURST_LEN,
    parameter int AFULL_TH  = (2**SDRAM_FIFO_ADDR) - 16,
    parameter int AEMPTY_TH = 16,
    parameter int SHOWAHEAD = 0
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             burst_rdy,
    output logic [ADDR:0]    usedw,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [ADDR:0] ONE_V    = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR:0] AFULL_V  = AFULL_TH[ADDR:0];
    localparam logic [ADDR:0] AEMPTY_V = AEMPTY_TH[ADDR:0];
    localparam logic [ADDR:0] BURST_V  = BURST_LEN[ADDR:0];

    logic [ADDR:0]    wr_ptr_r, rd_ptr_r, usedw_r;
    logic [ADDR:0]    wr_ptr_nxt_s, rd_ptr_nxt_s, usedw_nxt_s;
    logic             wr_en_s, rd_en_s;
    fifo_op_e         op_s;
    logic             full_r, empty_r, afull_r, aempty_r, burst_r, ovf_r, udf_r;
    logic             full_nxt_s, empty_nxt_s, afull_nxt_s, aempty_nxt_s, burst_nxt_s;
    logic             ovf_nxt_s, udf_nxt_s;
    logic             ram_rd_en_s;
    logic [ADDR-1:0]  ram_rd_addr_s;
    logic [WIDTH-1:0] ram_q_s;

    // Accept logic and next-state pointers/count; aclr gating keeps in-flight writes out of the RAM.
    always_comb begin
        wr_en_s      = wrreq & ~full_r & ~flush & ~aclr;
        rd_en_s      = rdreq & ~empty_r & ~flush & ~aclr;
        op_s         = fifo_op_e'({wr_en_s, rd_en_s});
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        usedw_nxt_s  = usedw_r;
        if (flush) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            usedw_nxt_s  = '0;
        end else begin
            case (op_s)
                FIFO_WR: begin
                    wr_ptr_nxt_s = wr_ptr_r + ONE_V;
                    usedw_nxt_s  = usedw_r + ONE_V;
                end
                FIFO_RD: begin
                    rd_ptr_nxt_s = rd_ptr_r + ONE_V;
                    usedw_nxt_s  = usedw_r - ONE_V;
                end
                FIFO_RW: begin
                    wr_ptr_nxt_s = wr_ptr_r + ONE_V;
                    rd_ptr_nxt_s = rd_ptr_r + ONE_V;
                end
                default: begin
                    usedw_nxt_s = usedw_r;
                end
            endcase
        end
    end

    // Next-state flags, so the registered flags always agree with usedw.
    always_comb begin
        full_nxt_s   = (wr_ptr_nxt_s[ADDR-1:0] == rd_ptr_nxt_s[ADDR-1:0]) &&
                       (wr_ptr_nxt_s[ADDR] != rd_ptr_nxt_s[ADDR]);
        empty_nxt_s  = (usedw_nxt_s == '0);
        afull_nxt_s  = (usedw_nxt_s >= AFULL_V);
        aempty_nxt_s = (usedw_nxt_s <= AEMPTY_V);
        burst_nxt_s  = (usedw_nxt_s >= BURST_V);
        if (flush) begin
            ovf_nxt_s = 1'b0;
            udf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r | (wrreq & full_r);
            udf_nxt_s = udf_r | (rdreq & empty_r);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            usedw_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            burst_r  <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            usedw_r  <= usedw_nxt_s;
            full_r   <= full_nxt_s;
            empty_r  <= empty_nxt_s;
            afull_r  <= afull_nxt_s;
            aempty_r <= aempty_nxt_s;
            burst_r  <= burst_nxt_s;
            ovf_r    <= ovf_nxt_s;
            udf_r    <= udf_nxt_s;
        end
    end

    fifo_ram_sdp #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_ram (
        .clk     (clk),
        .aclr    (aclr),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[ADDR-1:0]),
        .wr_data (data),
        .rd_en   (ram_rd_en_s),
        .rd_addr (ram_rd_addr_s),
        .rd_data (ram_q_s)
    );

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            logic [WIDTH-1:0] byp_data_r;
            logic             byp_sel_r;

            // The RAM prefetches the next head every cycle; when that head is being
            // written this same edge the RAM would return stale data, so bypass it.
            always_ff @(posedge clk or posedge aclr) begin
                if (aclr) begin
                    byp_data_r <= '0;
                    byp_sel_r  <= 1'b0;
                end else begin
                    byp_data_r <= data;
                    byp_sel_r  <= wr_en_s && (wr_ptr_r == rd_ptr_nxt_s);
                end
            end

            assign ram_rd_en_s   = 1'b1;
            assign ram_rd_addr_s = rd_ptr_nxt_s[ADDR-1:0];
            assign q             = byp_sel_r ? byp_data_r : ram_q_s;
        end else begin : g_normal
            assign ram_rd_en_s   = rd_en_s;
            assign ram_rd_addr_s = rd_ptr_r[ADDR-1:0];
            assign q             = ram_q_s;
        end
    endgenerate

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign burst_rdy    = burst_r;
    assign usedw        = usedw_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: tb/tb_sync_burst_fifo.sv
// Directed bench for sync_burst_fifo: one normal-mode and one show-ahead instance
// (ADDR=4, BURST_LEN=8, AFULL_TH=14, AEMPTY_TH=2) driven with the same stimulus.
module tb_sync_burst_fifo;

    logic        clk, aclr, flush, wrreq, rdreq;
    logic [15:0] data;
    logic [15:0] q0, q1;
    logic [4:0]  usedw0, usedw1;
    logic        full0, empty0, af0, ae0, br0, ovf0, udf0;
    logic        full1, empty1, af1, ae1, br1, ovf1, udf1;
    logic [6:0]  flags0, flags1;

    assign flags0 = {empty0, full0, af0, ae0, br0, ovf0, udf0};
    assign flags1 = {empty1, full1, af1, ae1, br1, ovf1, udf1};

    sync_burst_fifo #(.WIDTH(16), .ADDR(4), .BURST_LEN(8), .AFULL_TH(14), .AEMPTY_TH(2), .SHOWAHEAD(0)) dut0 (
        .clk(clk), .aclr(aclr), .flush(flush), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .burst_rdy(br0), .usedw(usedw0), .overflow(ovf0), .underflow(udf0));

    sync_burst_fifo #(.WIDTH(16), .ADDR(4), .BURST_LEN(8), .AFULL_TH(14), .AEMPTY_TH(2), .SHOWAHEAD(1)) dut1 (
        .clk(clk), .aclr(aclr), .flush(flush), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .q(q1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .burst_rdy(br1), .usedw(usedw1), .overflow(ovf1), .underflow(udf1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl, wr, rd;
        logic [15:0] d;
        logic [4:0]  uw;
        logic [6:0]  fg;
        logic        cq0;
        logic [15:0] q0;
        logic        cq1;
        logic [15:0] q1;
    } vec_t;

    vec_t tbl [34];
    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] sb [$];
    logic [15:0] exp_q;

    // Expected flag vector {empty, full, afull, aempty, burst, ovf, udf} for this configuration.
    function automatic logic [6:0] exp_flags(input int uw, input logic ovf, input logic udf);
        return {uw == 0, uw == 16, uw >= 14, uw <= 2, uw >= 8, ovf, udf};
    endfunction

    function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] d, input int uw,
                                input logic ovf, input logic udf, input logic cq0, input logic [15:0] eq0,
                                input logic cq1, input logic [15:0] eq1);
        vec_t v;
        v.fl = 1'b0; v.wr = wr; v.rd = rd; v.d = d;
        v.uw = 5'(uw); v.fg = exp_flags(uw, ovf, udf);
        v.cq0 = cq0; v.q0 = eq0; v.cq1 = cq1; v.q1 = eq1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic step(input logic fl, input logic wr, input logic rd, input logic [15:0] d);
        flush = fl; wrreq = wr; rdreq = rd; data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        aclr = 1'b1; flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 16'h0000;

        // Fill 1..16, one rejected write, drain 16, one rejected read.
        for (int k = 1; k <= 16; k++)
            tbl[k-1] = mk(1'b1, 1'b0, 16'(k), k, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001);
        tbl[16] = mk(1'b1, 1'b0, 16'h0011, 16, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001);
        for (int j = 1; j <= 16; j++)
            tbl[16+j] = mk(1'b0, 1'b1, 16'h0000, 16 - j, 1'b1, 1'b0, 1'b1, 16'(j), (j != 16), 16'(j + 1));
        tbl[33] = mk(1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000);

        #12;
        chk("rst_usedw", 32'(usedw0), 32'd0);
        chk("rst_flags0", 32'(flags0), 32'(exp_flags(0, 1'b0, 1'b0)));
        chk("rst_flags1", 32'(flags1), 32'(exp_flags(0, 1'b0, 1'b0)));
        chk("rst_q0", 32'(q0), 32'd0);
        chk("rst_q1", 32'(q1), 32'd0);
        aclr = 1'b0;

        for (int i = 0; i < 34; i++) begin
            step(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk($sformatf("row%0d_usedw", i), 32'(usedw0), 32'(tbl[i].uw));
            chk($sformatf("row%0d_flags0", i), 32'(flags0), 32'(tbl[i].fg));
            chk($sformatf("row%0d_flags1", i), 32'(flags1), 32'(tbl[i].fg));
            if (tbl[i].cq0) chk($sformatf("row%0d_q0", i), 32'(q0), 32'(tbl[i].q0));
            if (tbl[i].cq1) chk($sformatf("row%0d_q1", i), 32'(q1), 32'(tbl[i].q1));
        end

        // Flush clears the sticky flags.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("flush1_flags", 32'(flags0), 32'(exp_flags(0, 1'b0, 1'b0)));

        // Show-ahead: write into empty, then read+write the same cycle.
        step(1'b0, 1'b1, 1'b0, 16'hABCD);
        sb.push_back(16'hABCD);
        chk("sa_q1_first", 32'(q1), 32'h0000ABCD);
        chk("sa_usedw1", 32'(usedw1), 32'd1);
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        exp_q = sb.pop_front();
        sb.push_back(16'h1234);
        chk("sa_q1_refill", 32'(q1), 32'h00001234);
        chk("sa_usedw_refill", 32'(usedw1), 32'd1);
        chk("sa_q0_read", 32'(q0), 32'(exp_q));
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sa_q1_hold", 32'(q1), 32'h00001234);

        // Bring level to 5, then 20 cycles of simultaneous read+write across the wrap.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
            sb.push_back(16'(16'h0100 + i));
        end
        chk("rw_start_usedw", 32'(usedw0), 32'd5);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'(16'h0200 + i));
            exp_q = sb.pop_front();
            sb.push_back(16'(16'h0200 + i));
            chk($sformatf("rw%0d_usedw", i), 32'(usedw0), 32'd5);
            chk($sformatf("rw%0d_q0", i), 32'(q0), 32'(exp_q));
            chk($sformatf("rw%0d_q1", i), 32'(q1), 32'(sb[0]));
        end

        // Fill to full, then read+write at full: write is rejected.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'(16'h0300 + i));
            sb.push_back(16'(16'h0300 + i));
        end
        chk("full_flags", 32'(flags0), 32'(exp_flags(16, 1'b0, 1'b0)));
        step(1'b0, 1'b1, 1'b1, 16'hDEAD);
        exp_q = sb.pop_front();
        chk("full_rw_usedw", 32'(usedw0), 32'd15);
        chk("full_rw_ovf", 32'(ovf0), 32'd1);
        chk("full_rw_q0", 32'(q0), 32'(exp_q));
        chk("full_rw_q1", 32'(q1), 32'(sb[0]));

        // Drain to 9, then flush with a concurrent write.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'h0000);
            exp_q = sb.pop_front();
            chk($sformatf("drain9_q0_%0d", i), 32'(q0), 32'(exp_q));
        end
        chk("pre_flush_usedw", 32'(usedw0), 32'd9);
        chk("pre_flush_ovf", 32'(ovf0), 32'd1);
        step(1'b1, 1'b1, 1'b0, 16'hBEEF);
        chk("flush_usedw", 32'(usedw0), 32'd0);
        chk("flush_flags", 32'(flags0), 32'(exp_flags(0, 1'b0, 1'b0)));
        chk("flush_q0_kept", 32'(q0), 32'(exp_q));
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("post_flush_usedw", 32'(usedw0), 32'd0);
        chk("post_flush_empty", 32'(empty0), 32'd1);

        // Asynchronous reset between edges while a write and read are pending.
        step(1'b0, 1'b1, 1'b0, 16'h1111);
        step(1'b0, 1'b1, 1'b0, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h3333);
        chk("pre_aclr_q1", 32'(q1), 32'h00001111);
        flush = 1'b0; wrreq = 1'b1; rdreq = 1'b1; data = 16'h4444;
        #2 aclr = 1'b1;
        #1;
        chk("aclr_usedw", 32'(usedw0), 32'd0);
        chk("aclr_flags0", 32'(flags0), 32'(exp_flags(0, 1'b0, 1'b0)));
        chk("aclr_flags1", 32'(flags1), 32'(exp_flags(0, 1'b0, 1'b0)));
        chk("aclr_q0", 32'(q0), 32'd0);
        chk("aclr_q1", 32'(q1), 32'd0);
        #1 aclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("post_aclr_usedw", 32'(usedw0), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h5A5A);
        chk("post_aclr_usedw1", 32'(usedw0), 32'd1);
        chk("post_aclr_q1", 32'(q1), 32'h00005A5A);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        chk("post_aclr_q0", 32'(q0), 32'h00005A5A);
        chk("post_aclr_empty", 32'(flags0), 32'(exp_flags(0, 1'b0, 1'b0)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
